// File: rtl/ro_scan_sequencer.sv
// ro_scan_sequencer: steps through a bank of ring oscillators one at a time.
// For each RO it lets the oscillator settle, clears the frequency counter,
// opens the gate for a fixed window, waits for the count to cross into the
// clk domain, latches it, and streams it MSB-first to the UART transmitter.
// Optional feature macro: RO_SCAN_HEADER_EN prepends a zero-extended RO index
// byte to each RO's count bytes (5 bytes per RO instead of 4).
module ro_scan_sequencer #(
  parameter int NUM_RO     = 100,
  parameter int IDX_W      = 7,
  parameter int SETTLE_CYC = 1000,
  parameter int GATE_CYC   = 100000,
  parameter int HOLD_CYC   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic [NUM_RO-1:0] o_roEn,
  output logic              o_cntClr,
  output logic              o_cntGate,
  input  logic [31:0]       i_cntValue,
  output logic              o_txStart,
  output logic [7:0]        o_txData,
  input  logic              i_txDoneTick,
  output logic [IDX_W-1:0]  o_roIdx,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CLEAR,
    S_GATE,
    S_HOLD,
    S_SEND,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0]      GATE_LAST   = 32'(GATE_CYC - 1);
  localparam logic [31:0]      HOLD_LAST   = 32'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RO - 1);
  localparam logic [NUM_RO-1:0] ONE_HOT0   = {{(NUM_RO-1){1'b0}}, 1'b1};

`ifdef RO_SCAN_HEADER_EN
  // Byte 4 is the index header, bytes 3..0 are the count.
  localparam logic [2:0] FIRST_BYTE = 3'd4;
`else
  localparam logic [2:0] FIRST_BYTE = 3'd3;
`endif

  state_t              r_state;
  logic [31:0]         r_cnt;
  logic [31:0]         r_shadow;
  logic [2:0]          r_byteIdx;
  logic [NUM_RO-1:0]   r_roEn;
  logic                r_cntClr;
  logic                r_cntGate;
  logic                r_txStart;
  logic [7:0]          r_txData;
  logic [IDX_W-1:0]    r_roIdx;
  logic                r_busy;
  logic                r_done;

  // Pick the byte to present for a given position in the outgoing frame;
  // position numbering counts down so the MSB of the count goes out first.
  function automatic logic [7:0] selByte(input logic [31:0] val, input logic [2:0] b);
    logic [7:0] res;
    res = 8'h00;
    case (b)
`ifdef RO_SCAN_HEADER_EN
      3'd4:    res = 8'(r_roIdx);
`endif
      3'd3:    res = val[31:24];
      3'd2:    res = val[23:16];
      3'd1:    res = val[15:8];
      3'd0:    res = val[7:0];
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Whole scan sequence: one state register, all outputs registered so the
  // RO bank and counter see glitch-free controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_byteIdx <= '0;
      r_roEn    <= '0;
      r_cntClr  <= 1'b0;
      r_cntGate <= 1'b0;
      r_txStart <= 1'b0;
      r_txData  <= '0;
      r_roIdx   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cntClr <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_roIdx <= '0;
            r_roEn  <= ONE_HOT0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt    <= '0;
            r_cntClr <= 1'b1;
            r_state  <= S_CLEAR;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CLEAR: begin
          r_cnt     <= '0;
          r_cntGate <= 1'b1;
          r_state   <= S_GATE;
        end
        S_GATE: begin
          if (r_cnt == GATE_LAST) begin
            r_cnt     <= '0;
            r_cntGate <= 1'b0;
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt     <= '0;
            r_shadow  <= i_cntValue;
            r_byteIdx <= FIRST_BYTE;
            r_txData  <= selByte(i_cntValue, FIRST_BYTE);
            r_txStart <= 1'b1;
            r_state   <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_SEND: begin
          if (i_txDoneTick) begin
            if (r_byteIdx == 3'd0) begin
              r_txStart <= 1'b0;
              r_txData  <= '0;
              r_roEn    <= '0;
              r_state   <= S_NEXT;
            end else begin
              r_byteIdx <= r_byteIdx - 3'd1;
              r_txData  <= selByte(r_shadow, r_byteIdx - 3'd1);
            end
          end
        end
        S_NEXT: begin
          if (r_roIdx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_roIdx <= r_roIdx + IDX_W'(1);
            r_roEn  <= ONE_HOT0 << (r_roIdx + IDX_W'(1));
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_roIdx <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_roEn    = r_roEn;
  assign o_cntClr  = r_cntClr;
  assign o_cntGate = r_cntGate;
  assign o_txStart = r_txStart;
  assign o_txData  = r_txData;
  assign o_roIdx   = r_roIdx;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Bench for ro_scan_sequencer: small parameter set, UART responder that
// finishes each byte a few cycles after tx_start, and a phase-based
// reference model checked every cycle, plus literal byte/timing checks.
module tb_ro_scan_sequencer;

  localparam int NUM_RO = 3;
  localparam int IDX_W  = 2;
  localparam int S      = 4;
  localparam int G      = 10;
  localparam int H      = 2;
  localparam int PRE    = S + 1 + G + H;
`ifdef RO_SCAN_HEADER_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       cntValue = 32'hA1B2C3D4;
  logic              tick = 1'b0;
  logic              spuriousReq = 1'b0;
  logic [NUM_RO-1:0] o_roEn;
  logic              o_cntClr;
  logic              o_cntGate;
  logic              o_txStart;
  logic [7:0]        o_txData;
  logic [IDX_W-1:0]  o_roIdx;
  logic              o_busy;
  logic              o_done;

  int testsRun = 0;
  int testsFailed = 0;

  // model state: 0 idle, 1 working on an RO, 2 gap between ROs, 3 done pulse
  int          mMode = 0;
  int          mIdx = 0;
  int          mT = 0;
  int          mBytes = 0;
  logic [31:0] mShadow = '0;

  logic [7:0] sentBytes[$];
  logic [7:0] expBytes[$];
  int doneCount = 0;
  int clrCount = 0;
  int gateCount = 0;
  int settleCount = 0;

  always #5 clk = ~clk;

  ro_scan_sequencer #(
    .NUM_RO(NUM_RO), .IDX_W(IDX_W), .SETTLE_CYC(S), .GATE_CYC(G), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .reset(reset), .i_start(start),
    .o_roEn(o_roEn), .o_cntClr(o_cntClr), .o_cntGate(o_cntGate),
    .i_cntValue(cntValue), .o_txStart(o_txStart), .o_txData(o_txData),
    .i_txDoneTick(tick), .o_roIdx(o_roIdx), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [7:0] expByte(input logic [31:0] shadow, input int idx, input int k);
    int j;
    j = k - (NB - 4);
    if (j < 0) return 8'(idx);
    return 8'((shadow >> (24 - 8 * j)) & 32'hFF);
  endfunction

  // UART stand-in: finishes a byte 5 cycles after it sees tx_start, or
  // fires one stray tick on request.
  initial begin
    int uCnt;
    uCnt = 0;
    forever begin
      @(negedge clk);
      if (spuriousReq) begin
        tick = 1'b1;
        spuriousReq = 1'b0;
        uCnt = 0;
      end else if (tick) begin
        tick = 1'b0;
        uCnt = 0;
      end else if (o_txStart && !reset) begin
        uCnt++;
        if (uCnt == 5) tick = 1'b1;
      end else begin
        uCnt = 0;
      end
    end
  end

  // Reference model advanced on each edge from the inputs seen at that edge,
  // then compared against the DUT just after the edge.
  initial begin
    logic txExp;
    forever begin
      @(posedge clk);
      if (!reset && o_txStart && tick) sentBytes.push_back(o_txData);
      if (reset) begin
        mMode = 0; mIdx = 0; mT = 0; mBytes = 0;
      end else begin
        case (mMode)
          0: if (start) begin mMode = 1; mIdx = 0; mT = 0; mBytes = 0; end
          1: begin
            if (mT < PRE) begin
              if (mT == PRE - 1) mShadow = cntValue;
              mT++;
            end else if (tick) begin
              mBytes++;
              if (mBytes == NB) mMode = 2;
            end
          end
          2: begin
            if (mIdx == NUM_RO - 1) mMode = 3;
            else begin mIdx++; mT = 0; mBytes = 0; mMode = 1; end
          end
          default: begin mMode = 0; mIdx = 0; end
        endcase
      end
      #1;
      txExp = (mMode == 1) && (mT == PRE);
      checkOutput("busy", 64'(o_busy), 64'(mMode != 0));
      checkOutput("done", 64'(o_done), 64'(mMode == 3));
      checkOutput("roIdx", 64'(o_roIdx), 64'(mIdx));
      checkOutput("roEn", 64'(o_roEn), (mMode == 1) ? (64'd1 << mIdx) : 64'd0);
      checkOutput("cntClr", 64'(o_cntClr), 64'((mMode == 1) && (mT == S)));
      checkOutput("cntGate", 64'(o_cntGate), 64'((mMode == 1) && (mT >= S + 1) && (mT <= S + G)));
      checkOutput("txStart", 64'(o_txStart), 64'(txExp));
      if (txExp) checkOutput("txData", 64'(o_txData), 64'(expByte(mShadow, mIdx, mBytes)));
      if (o_done) doneCount++;
      if (o_cntGate) gateCount++;
      if (o_roEn != 0 && clrCount == 0 && !o_cntClr) settleCount++;
      if (o_cntClr) clrCount++;
    end
  end

  task automatic clearStats();
    sentBytes.delete();
    doneCount = 0; clrCount = 0; gateCount = 0; settleCount = 0;
  endtask

  task automatic waitDone(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_done) begin seen = 1'b1; break; end
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  task automatic checkScanBytes(input string name);
    checkOutput({name, "Count"}, 64'(sentBytes.size()), 64'(expBytes.size()));
    for (int i = 0; i < expBytes.size() && i < sentBytes.size(); i++)
      checkOutput({name, "Byte"}, 64'(sentBytes[i]), 64'(expBytes[i]));
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "RoEn"}, 64'(o_roEn), 64'd0);
    checkOutput({name, "Clr"}, 64'(o_cntClr), 64'd0);
    checkOutput({name, "Gate"}, 64'(o_cntGate), 64'd0);
    checkOutput({name, "TxStart"}, 64'(o_txStart), 64'd0);
    checkOutput({name, "TxData"}, 64'(o_txData), 64'd0);
    checkOutput({name, "RoIdx"}, 64'(o_roIdx), 64'd0);
    checkOutput({name, "Busy"}, 64'(o_busy), 64'd0);
    checkOutput({name, "Done"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    for (int r = 0; r < NUM_RO; r++) begin
`ifdef RO_SCAN_HEADER_EN
      expBytes.push_back(8'(r));
`endif
      expBytes.push_back(8'hA1);
      expBytes.push_back(8'hB2);
      expBytes.push_back(8'hC3);
      expBytes.push_back(8'hD4);
    end

    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // start coinciding with reset must not launch a scan
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstStartBusy", 64'(o_busy), 64'd0);
    checkOutput("rstStartRoEn", 64'(o_roEn), 64'd0);

    // full scan with stray start/tick during GATE and a count change mid-SEND
    clearStats();
    applyStimulus();
    for (int i = 0; i < 200 && !o_cntGate; i++) @(negedge clk);
    checkOutput("gateSeen", 64'(o_cntGate), 64'd1);
    spuriousReq = 1'b1;
    applyStimulus();
    for (int i = 0; i < 500 && !(o_roIdx == 1 && o_txStart); i++) @(negedge clk);
    checkOutput("ro1SendSeen", 64'(o_txStart), 64'd1);
    cntValue = 32'h11223344;
    applyStimulus();
    for (int i = 0; i < 500 && o_roEn != 3'b100; i++) @(negedge clk);
    checkOutput("ro2EnSeen", 64'(o_roEn), 64'h4);
    cntValue = 32'hA1B2C3D4;
    waitDone("scan1Done");
    @(negedge clk);
    checkOutput("scan1BusyAfter", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);
    checkScanBytes("scan1");
    checkOutput("scan1DonePulses", 64'(doneCount), 64'd1);
    checkOutput("scan1ClrCycles", 64'(clrCount), 64'd3);
    checkOutput("scan1GateCycles", 64'(gateCount), 64'd30);
    checkOutput("scan1SettleCycles", 64'(settleCount), 64'd4);

    // reset while RO 1's second byte is in flight
    clearStats();
    applyStimulus();
    for (int i = 0; i < 500 && sentBytes.size() < NB + 1; i++) @(negedge clk);
    checkOutput("midBytesSeen", 64'(sentBytes.size()), 64'(NB + 1));
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1 checkResetOutputs("midRst");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("postRstTxStart", 64'(o_txStart), 64'd0);
    checkOutput("postRstBytes", 64'(sentBytes.size()), 64'(NB + 1));

    // fresh scan restarts from RO 0
    clearStats();
    applyStimulus();
    checkOutput("rescanRoEn", 64'(o_roEn), 64'h1);
    checkOutput("rescanRoIdx", 64'(o_roIdx), 64'd0);
    waitDone("scan2Done");
    repeat (3) @(negedge clk);
    checkScanBytes("scan2");
    checkOutput("scan2DonePulses", 64'(doneCount), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
